// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader: converts streamed two's-complement LLRs to saturated sign-magnitude
// intrinsics and writes them over K*K PE blocks x L addresses, then runs one decode.
// Latency: one cycle from acceptance to write; back-pressure via in_ready (low outside LOAD).
// Ports: clk/reset (async, active-high); llr_in/in_valid/in_last/in_ready input stream;
//   int_in/load_add_in/pe_select/column_select intrinsic load bus; dec_en/dec_done decoder
//   handshake; frame_err one-cycle pulse on an in_last framing error.
module ldpc_llr_loader #(
  parameter int K             = 6,
  parameter int L             = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int MESSAGE_WIDTH = 5,
  parameter int IN_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_WIDTH-1:0]      llr_in,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [MESSAGE_WIDTH-1:0] int_in,
  output logic [ADDR_WIDTH-1:0]    load_add_in,
  output logic [K*K-1:0]           pe_select,
  output logic [K-1:0]             column_select,
  output logic                     dec_en,
  input  logic                     dec_done,
  output logic                     frame_err
);

  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int PW    = (K * K > 1) ? $clog2(K * K) : 1;
  localparam int MAG_W = MESSAGE_WIDTH - 1;
  localparam logic [IN_WIDTH-1:0] MAG_MAX = IN_WIDTH'((1 << MAG_W) - 1);

  typedef enum logic [1:0] {LOAD, FLUSH, DECODE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  // The PE counter is kept as (row, column) so the column one-hot needs no divider;
  // the linear PE index is row + column*K.
  logic [KW-1:0]            row_q, row_d;
  logic [KW-1:0]            col_q, col_d;
  logic [MESSAGE_WIDTH-1:0] int_q, int_d;
  logic [ADDR_WIDTH-1:0]    wadd_q, wadd_d;
  logic [K*K-1:0]           pe_sel_q, pe_sel_d;
  logic [K-1:0]             col_sel_q, col_sel_d;
  logic                     ferr_q, ferr_d;

  logic                     accept;
  logic                     addr_last;
  logic                     pe_last;
  logic [PW-1:0]            pe_idx;
  logic                     llr_sign;
  logic [IN_WIDTH-1:0]      llr_abs;
  logic [MAG_W-1:0]         llr_mag;
  logic [MESSAGE_WIDTH-1:0] llr_conv;

  // Unsigned absolute value: the most-negative input maps to 2^(IN_WIDTH-1), which is
  // still above MAG_MAX and so saturates correctly.
  always_comb begin
    llr_sign = llr_in[IN_WIDTH-1];
    llr_abs  = llr_sign ? (~llr_in + IN_WIDTH'(1)) : llr_in;
    llr_mag  = (llr_abs > MAG_MAX) ? MAG_MAX[MAG_W-1:0] : llr_abs[MAG_W-1:0];
    llr_conv = {llr_sign, llr_mag};
  end

  assign accept    = in_valid && in_ready;
  assign addr_last = (addr_q == ADDR_WIDTH'(L - 1));
  assign pe_last   = (row_q == KW'(K - 1)) && (col_q == KW'(K - 1));
  assign pe_idx    = PW'(row_q) + PW'(col_q) * PW'(K);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    row_d     = row_q;
    col_d     = col_q;
    int_d     = int_q;
    wadd_d    = wadd_q;
    pe_sel_d  = '0;
    col_sel_d = '0;
    ferr_d    = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          int_d             = llr_conv;
          wadd_d            = addr_q;
          pe_sel_d[pe_idx]  = 1'b1;
          col_sel_d[col_q]  = 1'b1;
          if (addr_last && pe_last) begin
            state_d = FLUSH;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
            ferr_d  = !in_last;
          end else if (in_last) begin
            // Early end of frame: keep this write but restart the frame from the top.
            addr_d = '0;
            row_d  = '0;
            col_d  = '0;
            ferr_d = 1'b1;
          end else if (addr_last) begin
            addr_d = '0;
            if (row_q == KW'(K - 1)) begin
              row_d = '0;
              col_d = col_q + KW'(1);
            end else begin
              row_d = row_q + KW'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      FLUSH:   state_d = DECODE;
      DECODE:  if (dec_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      int_q     <= '0;
      wadd_q    <= '0;
      pe_sel_q  <= '0;
      col_sel_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      int_q     <= int_d;
      wadd_q    <= wadd_d;
      pe_sel_q  <= pe_sel_d;
      col_sel_q <= col_sel_d;
      ferr_q    <= ferr_d;
    end
  end

  // in_ready is gated by reset so it reads 0 for as long as reset is held.
  assign in_ready      = (state_q == LOAD) && !reset;
  assign dec_en        = (state_q == DECODE);
  assign int_in        = int_q;
  assign load_add_in   = wadd_q;
  assign pe_select     = pe_sel_q;
  assign column_select = col_sel_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// tb_ldpc_llr_loader: directed bench for ldpc_llr_loader with a vector table for the
// LLR conversion and hand-written sequences for framing, decode handshake and reset.
module tb_ldpc_llr_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  llr_in;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [4:0]  int_in;
  logic [4:0]  load_add_in;
  logic [35:0] pe_select;
  logic [5:0]  column_select;
  logic        dec_en;
  logic        dec_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  ldpc_llr_loader dut (
    .clk          (clk),
    .reset        (reset),
    .llr_in       (llr_in),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .int_in       (int_in),
    .load_add_in  (load_add_in),
    .pe_select    (pe_select),
    .column_select(column_select),
    .dec_en       (dec_en),
    .dec_done     (dec_done),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] llr;
    logic       last;
    logic [4:0] exp_int;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion written with integer arithmetic.
  function automatic logic [4:0] conv_ref(input logic [7:0] v);
    int s;
    int m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    if (m > 15) m = 15;
    return 5'(m) | ((s < 0) ? 5'b10000 : 5'b00000);
  endfunction

  // Drive one beat, let it be accepted at the next edge, check the write it produced.
  // idx is the beat position within the current frame.
  task automatic beat(input logic [7:0] v, input logic last, input int idx,
                      input logic [4:0] exp_int, input logic exp_ferr);
    int          pe;
    logic [35:0] pe_oh;
    logic [5:0]  col_oh;
    llr_in   = v;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    pe       = idx / 32;
    pe_oh    = '0;
    pe_oh[pe] = 1'b1;
    col_oh   = '0;
    col_oh[pe / 6] = 1'b1;
    check($sformatf("write beat %0d {int,addr,pe,col}", idx),
          {int_in, load_add_in, pe_select, column_select},
          {exp_int, 5'(idx % 32), pe_oh, col_oh});
    check($sformatf("frame_err beat %0d", idx), frame_err, exp_ferr);
  endtask

  task automatic idle_cycle(input string name);
    @(posedge clk);
    #1;
    check(name, {pe_select, column_select, frame_err}, '0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {in_ready, int_in, load_add_in, pe_select, column_select, dec_en, frame_err}, '0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h7F, 1'b0, 5'b01111, 1'b0};  // +127
    vecs[1] = '{8'h80, 1'b0, 5'b11111, 1'b0};  // -128
    vecs[2] = '{8'hFB, 1'b0, 5'b10101, 1'b0};  // -5
    vecs[3] = '{8'h00, 1'b0, 5'b00000, 1'b0};  // 0
    vecs[4] = '{8'h0F, 1'b0, 5'b01111, 1'b0};  // +15
    vecs[5] = '{8'hF0, 1'b0, 5'b11111, 1'b0};  // -16
    vecs[6] = '{8'h10, 1'b0, 5'b01111, 1'b0};  // +16
    vecs[7] = '{8'hF1, 1'b0, 5'b11111, 1'b0};  // -15
    vecs[8] = '{8'h01, 1'b0, 5'b00001, 1'b0};  // +1
    vecs[9] = '{8'hFF, 1'b1, 5'b10001, 1'b1};  // -1, early in_last

    reset    = 1'b1;
    llr_in   = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    dec_done = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset outputs");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready after release", {in_ready, dec_en}, 2'b10);

    // Conversion table; the final entry carries an early in_last
    foreach (vecs[i]) beat(vecs[i].llr, vecs[i].last, i, vecs[i].exp_int, vecs[i].exp_ferr);
    idle_cycle("frame_err single pulse after table");

    // Ramp frame at full rate, restarting at addr 0 / PE 0
    for (int n = 0; n < 1152; n++) beat(8'(n % 16), n == 1151, n, 5'(n % 16), 1'b0);
    check("flush: ready low, dec_en low", {in_ready, dec_en}, 2'b00);
    @(posedge clk);
    #1;
    check("decode entry {pe_sel,dec_en}", {pe_select, dec_en}, {36'h0, 1'b1});

    // Decode handshake: hold dec_done low with a pending input that must not be taken
    llr_in   = 8'h55;
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("decode hold cyc %0d {ready,dec_en,pe_any}", c),
            {in_ready, dec_en, |pe_select}, 3'b010);
    end
    dec_done = 1'b1;
    @(posedge clk);
    #1;
    dec_done = 1'b0;
    in_valid = 1'b0;
    check("decode done {dec_en,ready}", {dec_en, in_ready}, 2'b01);

    // Gapped second frame with in_last on beat 40
    for (int n = 0; n <= 40; n++) begin
      logic [7:0] v;
      v = 8'(n * 29 + 3);
      beat(v, n == 40, n, conv_ref(v), n == 40);
      idle_cycle($sformatf("gap after beat %0d", n));
    end

    // Missing in_last on a full frame
    for (int n = 0; n < 1152; n++) begin
      logic [7:0] v;
      v = 8'(n * 37 + 11);
      beat(v, 1'b0, n, conv_ref(v), n == 1151);
    end
    @(posedge clk);
    #1;
    check("missing last: dec_en", {dec_en, frame_err}, 2'b10);

    // Reset during DECODE
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("reset in decode immediate");
    @(posedge clk);
    #1;
    check_all_zero("reset in decode held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after decode reset {ready,dec_en}", {in_ready, dec_en}, 2'b10);

    // Reset during beat 500
    for (int n = 0; n < 500; n++) beat(8'(n), 1'b0, n, conv_ref(8'(n)), 1'b0);
    llr_in   = 8'h33;
    in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("reset mid-frame immediate");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_all_zero("reset mid-frame held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after frame reset {ready,dec_en}", {in_ready, dec_en}, 2'b10);
    for (int n = 0; n < 4; n++) beat(8'hF8, 1'b0, n, 5'b11000, 1'b0);
    check("restart dec_en", dec_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_llr_loader.md
# ldpc_llr_loader

Front-end stage of the LDPC decoder: accepts a stream of two's-complement channel LLRs over a valid/ready handshake and converts each to saturated sign-magnitude intrinsic messages. It drives the decoder's intrinsic load bus (intrinsic data, load address, PE select, column select), walking all K×K PE blocks × L addresses in column-major PE order. Once a full frame is written, it holds the decoder enable high until the decoder reports completion, then accepts the next frame.

## Interface
- K, 6, PE array dimension (K×K PE blocks)
- L, 32, words per PE memory
- ADDR_WIDTH, 5, log2(L)
- MESSAGE_WIDTH, 5, sign-magnitude intrinsic width (1 sign + 4 magnitude)
- IN_WIDTH, 8, two's-complement input LLR width (IN_WIDTH ≥ MESSAGE_WIDTH)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- llr_in  in  IN_WIDTH  two's-complement LLR sample
- in_valid  in  1  llr_in is valid
- in_last  in  1  marks the final sample of a frame
- in_ready  out  1  loader can accept a sample this cycle
- int_in  out  MESSAGE_WIDTH  sign-magnitude intrinsic to the decoder
- load_add_in  out  ADDR_WIDTH  PE memory write address
- pe_select  out  K*K  one-hot PE write select, index p = i + j*K; all-zero means no write
- column_select  out  K  one-hot column of the selected PE; zero when no write
- dec_en  out  1  decoder enable, level
- dec_done  in  1  decoder finished the current frame
- frame_err  out  1  one-cycle pulse on an in_last framing error

## Operation
- States: LOAD, FLUSH, DECODE. Reset value is LOAD.
- Counters: addr (0..L-1) and pe (0..K*K-1). Both are 0 on reset.
- A beat is accepted when in_valid && in_ready. in_ready = 1 only in LOAD.
- On acceptance:
  - Register int_in = conv(llr_in) and load_add_in = addr.
  - Set pe_select = one-hot(pe) and column_select = one-hot(pe / K).
  - Increment addr. On wrap from L-1 to 0, increment pe.
- In a cycle with no acceptance, pe_select and column_select are 0. int_in and load_add_in hold their last value.
- Conversion conv:
  - sign = MSB of llr_in.
  - magnitude = |llr_in|, saturated to 2^(MESSAGE_WIDTH-1)-1 = 15. The most-negative input −2^(IN_WIDTH-1) also gives magnitude 15.
  - A zero input gives all-zero output. No negative zero is ever produced.
- Final beat (pe = K*K-1, addr = L-1) accepted: go to FLUSH and clear both counters.
- If in_last is not set on the final beat, pulse frame_err; the frame is still used.
- in_last on any earlier beat:
  - That beat is still written.
  - frame_err pulses.
  - Counters reset to 0 and the state stays LOAD, so the partial frame is discarded and overwritten.
- FLUSH lasts exactly one cycle. It then goes to DECODE with dec_en = 1.
- DECODE: in_ready = 0 and dec_en stays 1 until dec_done is sampled high. Then dec_en = 0 and the state returns to LOAD.
- dec_done outside DECODE is ignored.
- Reset asserted mid-frame or mid-decode:
  - All outputs go to 0 immediately (asynchronously).
  - Counters and state are cleared.
  - No partial-frame completion follows.

## Timing
- Reset values: in_ready 0 while reset is high, then 1 from the first cycle after release. int_in, load_add_in, pe_select, column_select, dec_en and frame_err are all 0.
- Write latency: a beat accepted at edge E has its write fields valid for the cycle after E. There is exactly one write cycle per beat.
- Full-rate streaming with in_valid held high gives one write per cycle, K*K*L = 1152 cycles per frame.
- Last beat accepted at edge E:
  - Edge E+1: pe_select = 0, dec_en = 1.
  - in_ready = 0 from the cycle after E.
- dec_done sampled high at edge D: dec_en = 0 and in_ready = 1 from the cycle after D.
- frame_err is registered and is high for the one cycle following the offending acceptance edge.
- Back-pressure is only via in_ready. llr_in must be held while in_valid is high and in_ready is low; it is not consumed.

## Test plan
- Ramp frame:
  - Stimulus: 1152 beats with llr_in = n mod 16, in_last on beat 1151.
  - Required: beat n writes load_add_in = n mod 32, pe_select bit n/32, column_select bit (n/32)/6.
  - Required: dec_en rises 2 edges after the last beat, and frame_err stays 0.
- Saturation:
  - Stimulus: llr_in = +127, −128, −5, 0, +15, −16.
  - Required: int_in = 0_1111, 1_1111, 1_0101, 0_0000, 0_1111, 1_1111.
- Gapped stream:
  - Stimulus: in_valid toggling 1/0.
  - Required: pe_select is nonzero only in cycles after accepted beats, and addresses are contiguous with no skips.
- Decode handshake:
  - Stimulus: after a full frame, hold dec_done = 0 for 100 cycles, then pulse it.
  - Required: in_ready = 0 and dec_en = 1 throughout, then dec_en = 0 and in_ready = 1 the next cycle.
  - Required: a second frame then starts at addr 0, PE 0.
- Early in_last:
  - Stimulus: in_last on beat 40.
  - Required: frame_err pulses once, and the next beat writes addr 0, PE 0.
- Missing in_last:
  - Stimulus: a full frame with no in_last on beat 1151.
  - Required: frame_err pulses once and dec_en still asserts.
- Reset:
  - Stimulus: assert reset during beat 500, and separately during DECODE.
  - Required: all outputs 0 immediately; after release, loading restarts from addr 0, PE 0 with dec_en = 0.
